// File: rtl/riscv_memory_access_pkg.sv
// rtl/riscv_memory_access_pkg.sv - shared encodings, M/W register layout and lane helpers for the RV32 M stage
package riscv_memory_access_pkg;

   localparam int RV_XLEN = 32;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      RS_ALU  = 2'b00,
      RS_LOAD = 2'b01,
      RS_PC4  = 2'b10,
      RS_IMM  = 2'b11
   } result_src_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            result_src;
      logic [RV_XLEN-1:0]    alu_result;
      logic [RV_XLEN-1:0]    read_data;
      logic [4:0]            rd;
      logic [RV_XLEN-1:0]    pc_plus_4;
      logic [RV_XLEN-1:0]    ext_imm;
   } mw_reg_t;

   // funct3[1:0] carries the access size; bit 2 only selects zero-extension.
   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_lo[0];
         default: misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   byte_enables = 4'b0001 << addr_lo;
         2'b01:   byte_enables = 4'b0011 << addr_lo;
         default: byte_enables = 4'b1111;
      endcase
   endfunction

   function automatic logic [RV_XLEN-1:0] store_lanes(input logic [2:0] funct3, input logic [RV_XLEN-1:0] wdata);
      case (funct3[1:0])
         2'b00:   store_lanes = {4{wdata[7:0]}};
         2'b01:   store_lanes = {2{wdata[15:0]}};
         default: store_lanes = wdata;
      endcase
   endfunction

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - shifts the read word down to the addressed lane and sign/zero-extends it
module riscv_load_align
   import riscv_memory_access_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_data
);

   logic [XLEN-1:0] shifted;

   // Word loads are always aligned when they reach here, so shifted equals rdata for them.
   assign shifted = i_rdata >> {i_addr_lo, 3'b000};

   always_comb begin
      o_data = shifted;
      case (i_funct3)
         F3_B:    o_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_H:    o_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   o_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_HU:   o_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: o_data = shifted;
      endcase
   end

endmodule

// File: rtl/riscv_memory_access.sv
// rtl/riscv_memory_access.sv - RV32 memory-access stage with req/ack data port and M/W register
// Optional bus-abort timeout is built when RISCV_DMEM_TIMEOUT_EN is defined.
module riscv_memory_access
   import riscv_memory_access_pkg::*;
#(
   parameter int XLEN           = RV_XLEN,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_reg_write_m,
   input  logic [1:0]      i_result_src_m,
   input  logic            i_mem_write_m,
   input  logic [XLEN-1:0] i_alu_result_m,
   input  logic [XLEN-1:0] i_write_data_m,
   input  logic [4:0]      i_rd_m,
   input  logic [XLEN-1:0] i_pc_plus_4m,
   input  logic [XLEN-1:0] i_ext_imm_m,
   input  logic [2:0]      i_funct3_m,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [XLEN-1:0] o_dmem_wdata,
   output logic [3:0]      o_dmem_be,
   input  logic            i_dmem_ack,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_stall_m,
   output logic            o_misalign_m,
   output logic            o_bus_err_w,
   output logic            o_reg_write_w,
   output logic [1:0]      o_result_src_w,
   output logic [XLEN-1:0] o_alu_result_w,
   output logic [XLEN-1:0] o_read_data_w,
   output logic [4:0]      o_rd_w,
   output logic [XLEN-1:0] o_pc_plus_4w,
   output logic [XLEN-1:0] o_ext_imm_w
);

   logic            is_load;
   logic            mem_op;
   logic            misalign;
   logic            active;
   logic            stall;
   logic            timeout_hit;
   logic [XLEN-1:0] load_data;
   mem_state_e      state_q, state_d;
   mw_reg_t         mw_q, mw_d;

   assign is_load  = (i_result_src_m == RS_LOAD);
   assign mem_op   = i_mem_write_m | is_load;
   assign misalign = mem_op & misaligned(i_funct3_m, i_alu_result_m[1:0]);
   assign active   = mem_op & ~misalign;

   // Gating with i_rstn drops the request the instant reset asserts, even mid-WAIT.
   assign o_dmem_req   = i_rstn & active;
   assign o_dmem_we    = o_dmem_req & i_mem_write_m;
   assign o_dmem_addr  = {i_alu_result_m[XLEN-1:2], 2'b00};
   assign o_dmem_be    = byte_enables(i_funct3_m, i_alu_result_m[1:0]);
   assign o_dmem_wdata = store_lanes(i_funct3_m, i_write_data_m);
   assign o_misalign_m = misalign;

   assign stall     = o_dmem_req & ~i_dmem_ack & ~timeout_hit;
   assign o_stall_m = stall;

   riscv_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .i_funct3  (i_funct3_m),
      .i_addr_lo (i_alu_result_m[1:0]),
      .i_rdata   (i_dmem_rdata),
      .o_data    (load_data)
   );

`ifdef RISCV_DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q;

   // cnt_q counts request cycles already spent, so expiry lands on the TIMEOUT_CYCLES-th request cycle.
   assign timeout_hit = (state_q == ST_WAIT) & active & ~i_dmem_ack
                      & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (active && !i_dmem_ack && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= timeout_hit;
      end
   end

   assign o_bus_err_w = bus_err_q;
`else
   assign timeout_hit = 1'b0;
   assign o_bus_err_w = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (active && !i_dmem_ack) state_d = ST_WAIT;
         ST_WAIT: if (!active || i_dmem_ack || timeout_hit) state_d = ST_IDLE;
      endcase
   end

   // A stalled or aborted cycle writes an all-zero bubble into W.
   always_comb begin
      mw_d = '0;
      if (!stall && !timeout_hit) begin
         mw_d.reg_write  = i_reg_write_m & ~misalign;
         mw_d.result_src = i_result_src_m;
         mw_d.alu_result = i_alu_result_m;
         mw_d.read_data  = (is_load & active) ? load_data : '0;
         mw_d.rd         = i_rd_m;
         mw_d.pc_plus_4  = i_pc_plus_4m;
         mw_d.ext_imm    = i_ext_imm_m;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         mw_q    <= '0;
      end else begin
         state_q <= state_d;
         mw_q    <= mw_d;
      end
   end

   assign o_reg_write_w  = mw_q.reg_write;
   assign o_result_src_w = mw_q.result_src;
   assign o_alu_result_w = mw_q.alu_result;
   assign o_read_data_w  = mw_q.read_data;
   assign o_rd_w         = mw_q.rd;
   assign o_pc_plus_4w   = mw_q.pc_plus_4;
   assign o_ext_imm_w    = mw_q.ext_imm;

endmodule

// File: doc/riscv_memory_access.md
# riscv_memory_access

Memory-access (M) stage of the pipelined RV32 core, directly downstream of the execute stage. Consumes the E/M pipeline register outputs, drives a request/acknowledge data-memory port with byte enables and store-data lane replication, and aligns and extends load data. Generates a stall while a memory access is outstanding, and owns the M/W pipeline register that feeds writeback.

## Interface
Parameters:
- XLEN, 32, datapath width (RV32 only)
- TIMEOUT_CYCLES, 64, cycles in WAIT before bus abort (used only with RISCV_DMEM_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_reg_write_m  in  1  register write enable from E/M register
- i_result_src_m  in  2  00 ALU, 01 load data, 10 PC+4, 11 immediate
- i_mem_write_m  in  1  store
- i_alu_result_m  in  XLEN  effective address / ALU result
- i_write_data_m  in  XLEN  store data (forwarded rs2)
- i_rd_m  in  5  destination register
- i_pc_plus_4m, i_ext_imm_m  in  XLEN  passthrough to W
- i_funct3_m  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  write strobe
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  XLEN  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  access complete; rdata valid same cycle for loads
- i_dmem_rdata  in  XLEN  read word
- o_stall_m  out  1  freeze F/D/E stages and E/M register
- o_misalign_m  out  1  misaligned access detected (combinational)
- o_bus_err_w  out  1  registered access abort (timeout build only, else tied 0)
- o_reg_write_w, o_result_src_w[1:0], o_alu_result_w, o_read_data_w, o_rd_w[4:0], o_pc_plus_4w, o_ext_imm_w  out  M/W register outputs

## Operation
- Memory op: i_mem_write_m or i_result_src_m==01, and aligned. Halfword misaligned: addr[0]=1; word misaligned: addr[1:0]!=0. A misaligned op raises o_misalign_m, issues no request, and does not stall; W receives reg_write 0.
- Byte enables: b -> 0001<<addr[1:0]; h -> 0011<<addr[1:0]; w -> 1111. Loads drive the same be, we=0.
- Store data: b replicated to all four bytes, h replicated to both halves, w unchanged.
- Load data: shift rdata right by 8*addr[1:0], then sign-extend (b/h) or zero-extend (bu/hu); w unchanged. The result is registered into o_read_data_w.
- FSM states:
  - IDLE: a memory op asserts o_dmem_req combinationally. With ack in the same cycle, complete (zero-wait); otherwise go to WAIT.
  - WAIT: hold req, we, addr, be and wdata stable until ack, then return to IDLE.
- o_stall_m = memory op active && !i_dmem_ack (combinational). Upstream holds M inputs stable while stalled.
- M/W register:
  - Loads from M on any non-stalled cycle.
  - While stalled it loads a bubble (reg_write_w=0, all other fields 0).
- i_dmem_ack outside an active request is ignored.

## Timing
- Reset: FSM to IDLE, timeout counter 0, every W output and o_bus_err_w cleared to 0. o_dmem_req is 0 in reset.
- Latency: non-memory ops and zero-wait accesses reach W one cycle after presentation. An access acked in WAIT after N cycles reaches W N+1 cycles after presentation.
- Reset asserted mid-WAIT: request dropped immediately; no completion is reported after reset releases.
- Back-to-back memory ops: a new request can issue in the cycle after ack, from IDLE.

## Configuration
- RISCV_DMEM_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 without ack, the block drops req, returns to IDLE, deasserts stall, and writes W with reg_write 0 and o_bus_err_w=1 for one cycle.
  - Ack in the same cycle as expiry wins: normal completion, no error.
- Undefined: WAIT lasts until ack; counter logic absent; o_bus_err_w tied 0.

## Structure
- Shared package/defines: XLEN, funct3 load/store encodings, result_src encodings, FSM state encodings.
- One sub-module, riscv_load_align: combinational rdata shift plus sign/zero extension, driven by funct3 and addr[1:0].

## Test plan
- sb addr 0x1003, data 0x000000A5, ack same cycle -> be=1000, wdata=0xA5A5A5A5, no stall, W reg_write 0.
- lh addr 0x2002, rdata 0x8001xxxx, ack after 3 wait cycles -> o_stall_m high 3 cycles, W bubbles, then read_data_w=0xFFFF8001.
- lbu addr 0x2001, rdata 0x0000F000 -> read_data_w=0x000000F0; lb gives 0xFFFFFFF0.
- lw addr 0x3002 -> o_misalign_m=1, req=0, no stall, W reg_write 0.
- Timeout build, TIMEOUT_CYCLES=4, no ack -> req held 4 cycles then dropped, o_bus_err_w=1 one cycle. Repeat with ack on cycle 4 -> normal completion, no error.
- i_rstn asserted in WAIT -> req, stall and all W outputs 0 immediately; after release, IDLE with no stale completion.
